p2s_serializer: RTL and testbench
=================================

Name: p2s_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the team's 4-bit serial-to-parallel deserializer and drives its data/vld inputs.
- Accepts parallel words over a valid/ready handshake into a 2-entry holding FIFO.
- Shifts each word out LSB-first, one bit per clk, with vld asserted for each bit.
- Inserts a guaranteed idle gap between words. The downstream deserializer spends one cycle clearing its bit counter after each word and does not count a bit presented in that cycle.

Parameters:
- WIDTH, 4, bits per parallel word; must match the downstream deserializer width; legal range 2..16.
- GAP, 1, idle cycles (vld_out=0) inserted after every word; minimum 1; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word; sampled when din_vld && din_rdy.
- din_vld  input  1  upstream word valid.
- din_rdy  output  1  FIFO can accept a word this cycle.
- data_out  output  1  serial bit; connects to the deserializer's data input.
- vld_out  output  1  serial bit valid; connects to the deserializer's vld input.
- word_done  output  1  one-cycle pulse coincident with the last bit of each word.
- busy  output  1  high while the FIFO is non-empty or the FSM is not in IDLE.

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk.
- While reset is asserted:
  - data_out, vld_out, word_done and busy are 0; din_rdy is 1.
  - FIFO is emptied; FSM goes to IDLE; bit and gap counters are cleared.
- All outputs are registered, except din_rdy = !fifo_full, which is decoded from registered FIFO state.
- Handshake and FIFO:
  - A word is accepted on a rising edge where din_vld && din_rdy.
  - din_vld may drop at any time without penalty.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - When full, din_rdy=0 even if a pop happens in that cycle; no combinational ready path.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if the FIFO is non-empty, pop on the next edge, load the shift register, drive data_out=word[0] and vld_out=1, set bitcnt=0, go to SHIFT.
  - SHIFT: on each edge, bitcnt++ and data_out = next higher bit. While bitcnt==WIDTH-1, word_done=1. On the following edge: vld_out=0, data_out=0, gapcnt=1, go to GAP.
  - GAP: vld_out=0. After GAP cycles of vld_out low, with the FIFO non-empty, load the next word directly (as in IDLE) with no extra cycle; otherwise go to IDLE.
- Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE has bit0 on data_out from edge N+1 and its last bit from edge N+WIDTH.
- Throughput: one word per WIDTH+GAP cycles when the FIFO is kept non-empty.
- vld_out is never high for more than WIDTH consecutive cycles, and never high during GAP.
- Counter widths: bitcnt is clog2(WIDTH) bits and gapcnt is clog2(GAP+1) bits; both are compared for equality and never wrap.
- Reset mid-word: the partial word is abandoned and the FIFO contents are discarded; vld_out falls immediately (asynchronously). After release, the FSM is in IDLE and the next accepted word is sent complete.
- busy falls in the cycle after the last GAP cycle when the FIFO is empty.

Decomposition:
- Shared package p2s_pkg:
  - state enum {IDLE, SHIFT, GAP};
  - default WIDTH and GAP constants, shared with the deserializer;
  - FIFO_DEPTH=2.
- One sub-module: p2s_fifo2. It is a 2-entry synchronous FIFO with push, pop, full, empty and dout, and n_rst async clear. The serializer top holds the FSM, shift register and counters.

Test Plan:
- Reset: assert n_rst=0 mid-simulation -> data_out=0, vld_out=0, word_done=0, busy=0, din_rdy=1 without waiting for a clock edge.
- Single word: din=4'b1011 accepted at edge 0 -> data_out 1,1,0,1 on cycles 1-4 with vld_out=1; word_done=1 in cycle 4; vld_out=0 in cycle 5. The attached deserializer reports dout=4'hB with dout_vld pulsing once.
- Back-to-back: din_vld held with words 0x1, 0x2, 0x3 (GAP=1):
  - din_rdy drops after the FIFO fills and recovers as words pop;
  - serial stream is 4 bits, 1 idle cycle, 4 bits, 1 idle cycle, 4 bits;
  - deserializer outputs 0x1, 0x2, 0x3 in order with no loss or duplication.
- GAP=3, WIDTH=8: two words 0xA5 and 0x3C -> exactly 3 vld_out-low cycles between them; 8 bits each, LSB-first; word_done pulses twice.
- Backpressure: FIFO full while din_vld toggles every cycle with changing din -> nothing accepted while din_rdy=0; only accepted words appear on the serial stream, once each.
- Reset mid-word: pulse n_rst low after 2 bits of 0xF with 0x6 queued -> vld_out falls immediately and both words are dropped. A new word 0x9 after release is sent complete as 1,0,0,1.

Source files
------------

// File: rtl/p2s_pkg.sv
// p2s_pkg
//   Shared definitions for the parallel-to-serial serializer slice.
//   The default word width and gap length match the downstream 4-bit
//   serial-to-parallel deserializer that this stage feeds.
//   Contents:
//     DEF_WIDTH  - default bits per parallel word
//     DEF_GAP    - default idle cycles inserted after every word
//     FIFO_DEPTH - entries in the input holding FIFO
//     state_e    - serializer FSM states (idle, shifting a word, idle gap)

package p2s_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_GAP    = 1;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/p2s_fifo2.sv
// p2s_fifo2
//   Two-entry synchronous FIFO that holds parallel words in front of the
//   serializer shift register. Push and pop in the same cycle are both
//   performed. A push while full and a pop while empty are ignored.
//   Ports:
//     clk    - clock, rising edge
//     n_rst  - asynchronous active-low reset, empties the FIFO
//     push   - write din this cycle
//     din    - word to write
//     pop    - drop the head entry this cycle
//     dout   - head entry (valid while empty is 0)
//     full   - both entries occupied
//     empty  - no entries occupied

module p2s_fifo2
   import p2s_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == 2'(FIFO_DEPTH));
   assign empty   = (count_q == 2'd0);
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      // Simultaneous push and pop leaves the occupancy unchanged.
      if (do_push && !do_pop) begin
         count_d = count_q + 2'd1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/p2s_serializer.sv
// p2s_serializer
//   Parallel-to-serial stage feeding the serial-to-parallel deserializer.
//   Words enter a 2-entry FIFO over a valid/ready handshake and are shifted
//   out LSB-first, one bit per clock with vld_out high, followed by GAP idle
//   cycles so the deserializer can clear its bit counter between words.
//   Ports:
//     clk       - clock, rising edge
//     n_rst     - asynchronous active-low reset
//     din       - parallel word, taken when din_vld && din_rdy
//     din_vld   - upstream word valid
//     din_rdy   - FIFO can take a word this cycle (not full)
//     data_out  - serial data bit
//     vld_out   - serial bit valid
//     word_done - pulse coincident with the last bit of each word
//     busy      - FIFO non-empty or FSM not idle

module p2s_serializer
   import p2s_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GAP   = DEF_GAP
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_vld,
   output logic             din_rdy,
   output logic             data_out,
   output logic             vld_out,
   output logic             word_done,
   output logic             busy
);

   localparam int BW = $clog2(WIDTH);
   localparam int GW = $clog2(GAP + 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic [GW-1:0]    gapcnt_q, gapcnt_d;
   logic             data_out_q, data_out_d;
   logic             vld_out_q, vld_out_d;
   logic             word_done_q, word_done_d;
   logic             busy_q, busy_d;

   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_dout;
   logic             push;
   logic             load;

   // Ready comes only from registered FIFO state, so a pop in the same
   // cycle never opens a full FIFO combinationally.
   assign din_rdy = !fifo_full;
   assign push    = din_vld && din_rdy;

   p2s_fifo2 #(
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (push),
      .din   (din),
      .pop   (load),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      gapcnt_d    = gapcnt_q;
      data_out_d  = 1'b0;
      vld_out_d   = 1'b0;
      word_done_d = 1'b0;
      load        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            load = !fifo_empty;
         end

         ST_SHIFT: begin
            if (bitcnt_q == BW'(WIDTH - 1)) begin
               state_d  = ST_GAP;
               gapcnt_d = GW'(1);
            end else begin
               bitcnt_d    = bitcnt_q + BW'(1);
               data_out_d  = shreg_q[0];
               shreg_d     = shreg_q >> 1;
               vld_out_d   = 1'b1;
               // The pulse is registered, so it is raised on the edge that
               // presents the last bit.
               word_done_d = (bitcnt_q == BW'(WIDTH - 2));
            end
         end

         ST_GAP: begin
            if (gapcnt_q == GW'(GAP)) begin
               if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gapcnt_d = gapcnt_q + GW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Loading pops the FIFO head and presents bit 0 straight away; the
      // shift register keeps only the bits still to be sent.
      if (load) begin
         state_d    = ST_SHIFT;
         shreg_d    = fifo_dout >> 1;
         data_out_d = fifo_dout[0];
         vld_out_d  = 1'b1;
         bitcnt_d   = '0;
      end

      // A pop always means the FSM leaves idle, so the FIFO's pre-edge
      // emptiness plus any push is enough to predict its next occupancy.
      busy_d = (state_d != ST_IDLE) || push || !fifo_empty;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         gapcnt_q    <= '0;
         data_out_q  <= 1'b0;
         vld_out_q   <= 1'b0;
         word_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         gapcnt_q    <= gapcnt_d;
         data_out_q  <= data_out_d;
         vld_out_q   <= vld_out_d;
         word_done_q <= word_done_d;
         busy_q      <= busy_d;
      end
   end

   assign data_out  = data_out_q;
   assign vld_out   = vld_out_q;
   assign word_done = word_done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: one instance with WIDTH=4/GAP=1 and one with
// WIDTH=8/GAP=3, driven side by side and checked every cycle against a
// timeline model (queue of held words plus the start edge of the word in
// flight).

module tb_p2s_serializer;

   logic       clk;
   logic       n_rst;
   logic [3:0] din0;
   logic [7:0] din1;
   logic [1:0] vldIn;
   logic [1:0] rdyS;
   logic [1:0] dataS;
   logic [1:0] vldS;
   logic [1:0] doneS;
   logic [1:0] busyS;

   int total = 0;
   int bad   = 0;
   int ecount = 0;

   // Reference model state, one slot per instance.
   int mw[2] = '{4, 8};
   int mg[2] = '{1, 3};
   int mq[2][$];
   int curWord[2];
   int curStart[2];
   int nextStart[2];
   bit active[2];
   bit accFlag[2];
   int stimWord[2];
   bit stimVld[2];

   p2s_serializer #(.WIDTH(4), .GAP(1)) dut0 (
      .clk       (clk),
      .n_rst     (n_rst),
      .din       (din0),
      .din_vld   (vldIn[0]),
      .din_rdy   (rdyS[0]),
      .data_out  (dataS[0]),
      .vld_out   (vldS[0]),
      .word_done (doneS[0]),
      .busy      (busyS[0])
   );

   p2s_serializer #(.WIDTH(8), .GAP(3)) dut1 (
      .clk       (clk),
      .n_rst     (n_rst),
      .din       (din1),
      .din_vld   (vldIn[1]),
      .din_rdy   (rdyS[1]),
      .data_out  (dataS[1]),
      .vld_out   (vldS[1]),
      .word_done (doneS[1]),
      .busy      (busyS[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0b expected=%0b at edge %0d", tag, obs, exp, ecount);
      end
   endtask

   task automatic applyStimulus(input int d, input bit vld, input int word);
      stimVld[d]  = vld;
      stimWord[d] = word & ((1 << mw[d]) - 1);
      if (d == 0) begin
         din0     = 4'(stimWord[0]);
         vldIn[0] = vld;
      end else begin
         din1     = 8'(stimWord[1]);
         vldIn[1] = vld;
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         mq[d].delete();
         active[d]    = 1'b0;
         nextStart[d] = 0;
         accFlag[d]   = 1'b0;
      end
   endtask

   // One rising edge: a held word starts once the previous word and its gap
   // are over; a word offered while fewer than two are held is taken.
   task automatic modelEdge(input int d);
      bit acc;
      if (n_rst) begin
         acc = stimVld[d] && (mq[d].size() < 2);
         if (mq[d].size() > 0 && ecount >= nextStart[d]) begin
            curWord[d]   = mq[d].pop_front();
            curStart[d]  = ecount;
            active[d]    = 1'b1;
            nextStart[d] = ecount + mw[d] + mg[d];
         end
         if (acc) mq[d].push_back(stimWord[d]);
         accFlag[d] = acc;
      end else begin
         accFlag[d] = 1'b0;
      end
   endtask

   task automatic checkOutput();
      for (int d = 0; d < 2; d++) begin
         int   k;
         logic eV, eD, eDone, eBusy, eRdy;
         k     = ecount - curStart[d];
         eV    = active[d] && (k >= 0) && (k < mw[d]);
         eD    = eV ? 1'((curWord[d] >> k) & 1) : 1'b0;
         eDone = active[d] && (k == mw[d] - 1);
         eBusy = (mq[d].size() > 0) || (active[d] && ecount < nextStart[d]);
         eRdy  = (mq[d].size() < 2);
         cmp($sformatf("vld_out%0d", d),   vldS[d],  eV);
         cmp($sformatf("data_out%0d", d),  dataS[d], eD);
         cmp($sformatf("word_done%0d", d), doneS[d], eDone);
         cmp($sformatf("busy%0d", d),      busyS[d], eBusy);
         cmp($sformatf("din_rdy%0d", d),   rdyS[d],  eRdy);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      ecount++;
      modelEdge(0);
      modelEdge(1);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idleCycles(input int n);
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b0, 0);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   initial begin
      int idx;

      // Power-on reset, checked before any clock edge.
      n_rst = 1'b0;
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b0, 0);
      modelReset();
      #1;
      checkOutput();
      stepCycle();
      stepCycle();
      n_rst = 1'b1;
      $display("[TB] reset released");

      // Single word 0xB on the narrow instance; 0xA5 then 0x3C on the wide one.
      applyStimulus(0, 1'b1, 'hB);
      applyStimulus(1, 1'b1, 'hA5);
      stepCycle();
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b1, 'h3C);
      stepCycle();
      idleCycles(30);

      // Back-to-back 0x1, 0x2, 0x3 with din_vld held.
      idx = 0;
      for (int c = 0; c < 40 && idx < 3; c++) begin
         applyStimulus(0, 1'b1, idx + 1);
         applyStimulus(1, 1'b1, idx + 'h81);
         stepCycle();
         if (accFlag[0]) idx++;
      end
      idleCycles(25);

      // Backpressure: din_vld toggling with changing data, then random.
      for (int c = 0; c < 40; c++) begin
         applyStimulus(0, bit'(c & 1), $urandom);
         applyStimulus(1, bit'(c & 1), $urandom);
         stepCycle();
      end
      for (int c = 0; c < 60; c++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), $urandom);
         applyStimulus(1, 1'($urandom_range(0, 1)), $urandom);
         stepCycle();
      end
      idleCycles(30);

      // Reset mid-word: 0xF in flight with 0x6 queued.
      applyStimulus(0, 1'b1, 'hF);
      applyStimulus(1, 1'b1, 'hFF);
      stepCycle();
      applyStimulus(0, 1'b1, 'h6);
      applyStimulus(1, 1'b1, 'h66);
      stepCycle();
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b0, 0);
      for (int c = 0; c < 10; c++) begin
         if (active[0] && (ecount - curStart[0] == 1)) break;
         stepCycle();
      end
      n_rst = 1'b0;
      #1;
      modelReset();
      checkOutput();
      stepCycle();
      stepCycle();
      n_rst = 1'b1;
      $display("[TB] mid-word reset released");

      // A fresh word after reset is sent complete.
      applyStimulus(0, 1'b1, 'h9);
      applyStimulus(1, 1'b1, 'h5A);
      stepCycle();
      idleCycles(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
